pwm_duty_decoder: RTL and testbench

- Receive-side counterpart of the 8-bit PWM generator.
- Samples an incoming PWM waveform on the same CE tick grid that the generator uses.
- Measures the high time and the period between rising edges, then recovers the duty word D.
- Flags a constant-level input (D=0 all low, D=max all high) through an edge timeout. Sits at the front of the feedback/loopback path, driving duty monitoring logic.

---
 rtl/pwm_duty_decoder_pkg.sv | 30 +++
 rtl/pwm_duty_decoder_in_sync.sv | 58 +++++
 rtl/pwm_duty_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_decoder_pkg.sv
// -----------------------------------------------------------------------------
// pwm_duty_decoder_pkg
//
// Shared definitions for the PWM duty decoder slice:
//   - DEFAULT_WIDTH        : default duty word width (generator period 2^WIDTH)
//   - DEFAULT_SYNC_STAGES  : default synchroniser depth on the PWM input
//   - state_e              : decoder FSM encoding (SEEK / HIGH / LOW)
//   - timeout_ticks()      : number of CE ticks without an edge before the
//                            input is reported as a constant level
// -----------------------------------------------------------------------------
package pwm_duty_decoder_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // SEEK : waiting for the first rising edge, partial periods are ignored
  // HIGH : measuring the high phase of the current period
  // LOW  : measuring the low phase, next rise closes the period
  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Two full generator periods without any edge means the input is stuck.
  function automatic int timeout_ticks(input int width);
    return 2 ** (width + 1);
  endfunction

endpackage

// File: rtl/pwm_duty_decoder_in_sync.sv
// -----------------------------------------------------------------------------
// pwm_in_sync
//
// Brings the asynchronous PWM input into the CLK domain and produces the
// CE-tick level and edge strobes used by the duty decoder.
//
// Ports:
//   clk_i    in   system clock
//   rst_i    in   synchronous active-high reset (edge detector only)
//   ce_i     in   tick enable; level sampling and edge detection use it
//   async_i  in   asynchronous PWM input
//   lvl_o    out  synchronised level (valid for sampling on CE ticks)
//   rise_o   out  rising edge seen on this CE tick
//   fall_o   out  falling edge seen on this CE tick
// -----------------------------------------------------------------------------
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic async_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_lvl_q;
  logic                   primed_q;

  // The synchroniser chain is free-running and deliberately not reset: it
  // must keep tracking the pin through a reset so that the first CE tick
  // afterwards sees the real line level rather than a forced zero.
  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  assign lvl_o = sync_q[SYNC_STAGES-1];

  // prev_lvl only advances on CE ticks. The first tick after reset just
  // loads the current level (primed_q) so that a line that is already high
  // when reset is released is not mistaken for a fresh rising edge in the
  // middle of a pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_lvl_q <= 1'b0;
      primed_q   <= 1'b0;
    end else if (ce_i) begin
      prev_lvl_q <= lvl_o;
      primed_q   <= 1'b1;
    end
  end

  assign rise_o = ce_i & primed_q &  lvl_o & ~prev_lvl_q;
  assign fall_o = ce_i & primed_q & ~lvl_o &  prev_lvl_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// -----------------------------------------------------------------------------
// pwm_duty_decoder
//
// Receive-side counterpart of the WIDTH-bit PWM generator. Samples PWM_IN on
// the CE tick grid, measures the high time and the rise-to-rise period, and
// recovers the duty word (a high time of N ticks reports D = N-1). A line
// that shows no edge for TIMEOUT_TICKS ticks is reported as a constant
// level (D = 0 when stuck low, D = all-ones when stuck high).
//
// Ports:
//   CLK           in   system clock
//   RST           in   synchronous active-high reset
//   CE            in   tick enable; all counting/sampling happens on CE ticks
//   PWM_IN        in   asynchronous PWM input
//   D_OUT         out  recovered duty word
//   PERIOD_OUT    out  measured period in ticks (saturating)
//   VALID         out  one-CLK strobe when D_OUT/PERIOD_OUT are updated
//   TIMEOUT_FLAG  out  last report came from an edge timeout
//   LOCKED        out  a full period has been measured since reset/timeout
// -----------------------------------------------------------------------------
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_TICKS = timeout_ticks(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             PWM_IN,
  output logic [WIDTH-1:0] D_OUT,
  output logic [WIDTH+1:0] PERIOD_OUT,
  output logic             VALID,
  output logic             TIMEOUT_FLAG,
  output logic             LOCKED
);

  localparam int HW = WIDTH + 1;  // high_cnt width
  localparam int PW = WIDTH + 2;  // period_cnt / idle_cnt width

  // A high time above one full generator period cannot map to a legal duty
  // word, so anything beyond this clamps D_OUT to all-ones.
  localparam logic [HW-1:0] FULL_SCALE = HW'(2 ** WIDTH);
  localparam logic [PW-1:0] TIMEOUT_C  = PW'(TIMEOUT_TICKS);

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detection
  // ---------------------------------------------------------------------------
  logic lvl;
  logic rise;
  logic fall;

  pwm_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk_i   (CLK),
    .rst_i   (RST),
    .ce_i    (CE),
    .async_i (PWM_IN),
    .lvl_o   (lvl),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // ---------------------------------------------------------------------------
  // State, counters and output registers
  // ---------------------------------------------------------------------------
  state_e            state_q,        state_d;
  logic [HW-1:0]     high_cnt_q,     high_cnt_d;
  logic [PW-1:0]     period_cnt_q,   period_cnt_d;
  logic [PW-1:0]     idle_cnt_q,     idle_cnt_d;
  logic [WIDTH-1:0]  d_out_q,        d_out_d;
  logic [PW-1:0]     period_out_q,   period_out_d;
  logic              valid_q,        valid_d;
  logic              timeout_flag_q, timeout_flag_d;
  logic              locked_q,       locked_d;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------
  logic [HW-1:0]    high_inc;
  logic [PW-1:0]    period_inc;
  logic [PW-1:0]    idle_inc;
  logic [HW-1:0]    high_minus1;
  logic [WIDTH-1:0] duty_meas;
  logic             timeout_hit;

  // Both measurement counters saturate instead of wrapping so that an
  // abnormally long phase can never alias onto a small value.
  assign high_inc    = (&high_cnt_q)   ? high_cnt_q   : high_cnt_q   + HW'(1);
  assign period_inc  = (&period_cnt_q) ? period_cnt_q : period_cnt_q + PW'(1);
  assign idle_inc    = idle_cnt_q + PW'(1);

  assign high_minus1 = high_cnt_q - HW'(1);
  assign duty_meas   = (high_cnt_q > FULL_SCALE) ? '1 : high_minus1[WIDTH-1:0];

  // An edge on the same tick restarts the idle count, so a rise coinciding
  // with the timeout boundary wins and no constant-level report is made.
  assign timeout_hit = CE & ~rise & ~fall & (idle_inc == TIMEOUT_C);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    high_cnt_d     = high_cnt_q;
    period_cnt_d   = period_cnt_q;
    idle_cnt_d     = idle_cnt_q;
    d_out_d        = d_out_q;
    period_out_d   = period_out_q;
    valid_d        = 1'b0;
    timeout_flag_d = timeout_flag_q;
    locked_d       = locked_q;

    if (CE) begin
      if (rise || fall || timeout_hit) begin
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_inc;
      end

      if (timeout_hit) begin
        // Constant line: report the level it is stuck at and start over.
        d_out_d        = lvl ? '1 : '0;
        period_out_d   = '0;
        valid_d        = 1'b1;
        timeout_flag_d = 1'b1;
        locked_d       = 1'b0;
        high_cnt_d     = '0;
        period_cnt_d   = '0;
        state_d        = SEEK;
      end else begin
        case (state_q)
          SEEK: begin
            if (rise) begin
              high_cnt_d   = HW'(1);
              period_cnt_d = PW'(1);
              state_d      = HIGH;
            end
          end

          HIGH: begin
            period_cnt_d = period_inc;
            if (fall) begin
              state_d = LOW;
            end else begin
              high_cnt_d = high_inc;
            end
          end

          LOW: begin
            if (rise) begin
              // Rise closes the period: publish, then this tick becomes the
              // first high tick of the next period.
              d_out_d        = duty_meas;
              period_out_d   = period_cnt_q;
              valid_d        = 1'b1;
              timeout_flag_d = 1'b0;
              locked_d       = 1'b1;
              high_cnt_d     = HW'(1);
              period_cnt_d   = PW'(1);
              state_d        = HIGH;
            end else begin
              period_cnt_d = period_inc;
            end
          end

          default: begin
            state_d = SEEK;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= SEEK;
      high_cnt_q     <= '0;
      period_cnt_q   <= '0;
      idle_cnt_q     <= '0;
      d_out_q        <= '0;
      period_out_q   <= '0;
      valid_q        <= 1'b0;
      timeout_flag_q <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      high_cnt_q     <= high_cnt_d;
      period_cnt_q   <= period_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      d_out_q        <= d_out_d;
      period_out_q   <= period_out_d;
      valid_q        <= valid_d;
      timeout_flag_q <= timeout_flag_d;
      locked_q       <= locked_d;
    end
  end

  assign D_OUT        = d_out_q;
  assign PERIOD_OUT   = period_out_q;
  assign VALID        = valid_q;
  assign TIMEOUT_FLAG = timeout_flag_q;
  assign LOCKED       = locked_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_decoder
//
// Directed bench for pwm_duty_decoder (WIDTH=8). Drives generator-shaped PWM
// waveforms tick by tick, records every VALID report with its CLK cycle, and
// compares the reports against hand-computed duty words, periods, flags and
// report spacings.
// -----------------------------------------------------------------------------
module tb_pwm_duty_decoder;

  logic       CLK;
  logic       RST;
  logic       CE;
  logic       PWM_IN;
  logic [7:0] D_OUT;
  logic [9:0] PERIOD_OUT;
  logic       VALID;
  logic       TIMEOUT_FLAG;
  logic       LOCKED;

  pwm_duty_decoder dut (
    .CLK          (CLK),
    .RST          (RST),
    .CE           (CE),
    .PWM_IN       (PWM_IN),
    .D_OUT        (D_OUT),
    .PERIOD_OUT   (PERIOD_OUT),
    .VALID        (VALID),
    .TIMEOUT_FLAG (TIMEOUT_FLAG),
    .LOCKED       (LOCKED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Report monitor
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  d;
    logic [9:0]  p;
    logic        tf;
    logic        lk;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] cyc_cnt   = 0;
  logic        valid_last = 1'b0;
  int          wide_cnt  = 0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  always @(negedge CLK) begin
    if (VALID === 1'b1) begin
      evq.push_back('{cyc_cnt, D_OUT, PERIOD_OUT, TIMEOUT_FLAG, LOCKED});
      $display("report cyc=%0d d=%0d period=%0d tflag=%0d locked=%0d",
               cyc_cnt, D_OUT, PERIOD_OUT, TIMEOUT_FLAG, LOCKED);
      if (valid_last === 1'b1) wide_cnt <= wide_cnt + 1;
    end
    valid_last <= VALID;
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_ev(input string tag, input int idx, input int d, input int p,
                          input int tf, input int lk);
    if (idx >= evq.size()) begin
      check({tag, "_present"}, 32'(evq.size()), 32'(idx + 1));
    end else begin
      check({tag, "_d"},      32'(evq[idx].d),  32'(d));
      check({tag, "_period"}, 32'(evq[idx].p),  32'(p));
      check({tag, "_tflag"},  32'(evq[idx].tf), 32'(tf));
      check({tag, "_locked"}, 32'(evq[idx].lk), 32'(lk));
    end
  endtask

  function automatic logic [31:0] ev_cyc(input int idx);
    if (idx < evq.size()) return evq[idx].cyc;
    return 32'd0;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_d"},      32'(D_OUT),        0);
    check({tag, "_period"}, 32'(PERIOD_OUT),   0);
    check({tag, "_valid"},  32'(VALID),        0);
    check({tag, "_tflag"},  32'(TIMEOUT_FLAG), 0);
    check({tag, "_locked"}, 32'(LOCKED),       0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers: one generator tick lasts div CLK cycles, CE on the first
  // ---------------------------------------------------------------------------
  task automatic drive_tick(input logic lvl, input int div);
    for (int k = 0; k < div; k++) begin
      PWM_IN = lvl;
      CE     = (k == 0);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic gen_period(input int d, input int div);
    for (int t = 0; t < 256; t++) drive_tick(t <= d, div);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  logic [31:0] vr;

  initial begin
    RST    = 1'b1;
    CE     = 1'b0;
    PWM_IN = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    evq.delete();

    // D=3, four periods: first report only after the second rise.
    repeat (4) gen_period(3, 1);
    check("p1_count", 32'(evq.size()), 3);
    for (int i = 0; i < 3; i++) check_ev($sformatf("p1_ev%0d", i), i, 3, 256, 0, 1);
    check("p1_gap0", ev_cyc(1) - ev_cyc(0), 256);
    check("p1_gap1", ev_cyc(2) - ev_cyc(1), 256);

    // Duty change 128 -> 10 at a period boundary.
    evq.delete();
    gen_period(128, 1);
    gen_period(10, 1);
    gen_period(10, 1);
    check("p2_count", 32'(evq.size()), 3);
    check_ev("p2_ev0", 0, 3,   256, 0, 1);
    check_ev("p2_ev1", 1, 128, 256, 0, 1);
    check_ev("p2_ev2", 2, 10,  256, 0, 1);
    vr = ev_cyc(2);

    // Held low: last edge is the fall 11 ticks after the last reported rise.
    evq.delete();
    repeat (1100) drive_tick(1'b0, 1);
    check("p3_count", 32'(evq.size()), 2);
    check_ev("p3_ev0", 0, 0, 0, 1, 0);
    check_ev("p3_ev1", 1, 0, 0, 1, 0);
    check("p3_first_tmo", ev_cyc(0) - vr, 523);
    check("p3_repeat",    ev_cyc(1) - ev_cyc(0), 512);
    check("p3_locked_out", 32'(LOCKED), 0);
    check("p3_tflag_out",  32'(TIMEOUT_FLAG), 1);

    // Held high: constant-high timeout report.
    evq.delete();
    repeat (600) drive_tick(1'b1, 1);
    check("p4_count", 32'(evq.size()), 1);
    check_ev("p4_ev0", 0, 255, 0, 1, 0);

    // Normal waveform D=20 after the timeout relocks.
    evq.delete();
    repeat (3) gen_period(20, 1);
    check("p5_count", 32'(evq.size()), 1);
    check_ev("p5_ev0", 0, 20, 256, 0, 1);
    check("p5_d_out",  32'(D_OUT), 20);
    check("p5_locked", 32'(LOCKED), 1);

    // CE every 4th CLK, D=100 (first report straddles the grid change).
    evq.delete();
    repeat (3) gen_period(100, 4);
    check("p6_count", 32'(evq.size()), 3);
    check_ev("p6_ev1", 1, 100, 256, 0, 1);
    check_ev("p6_ev2", 2, 100, 256, 0, 1);
    check("p6_gap", ev_cyc(2) - ev_cyc(1), 1024);

    // Reset pulse while in the HIGH state.
    for (int t = 0; t < 10; t++) drive_tick(1'b1, 1);
    RST    = 1'b1;
    CE     = 1'b1;
    PWM_IN = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_outputs_zero("p7_rst");
    evq.delete();
    for (int t = 11; t < 256; t++) drive_tick(t <= 50, 1);
    repeat (2) gen_period(50, 1);
    check("p7_count", 32'(evq.size()), 1);
    check_ev("p7_ev0", 0, 50, 256, 0, 1);

    check("valid_width", 32'(wide_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
